multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RISC-V core. It replaces single-cycle opcode decoding with a state machine that steps one shared ALU and one shared memory port through fetch, decode, execute, memory and write-back. Each datapath write enable is asserted only in the cycle that owns it. It sits between the instruction register's opcode field, the ALU zero flag, the unified memory port and the datapath muxes and enables.

---
 rtl/multicycle_ctrl_pkg.sv | 73 +++++++
 rtl/mctrl_out_decode.sv | 92 +++++++++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multi-cycle sequencing controller: state
//   encoding, RISC-V opcode constants, ALU operation codes, ALU operand
//   select encodings and the bundle of datapath control signals that the
//   output decoder hands to the top level.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  // Controller states; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Supported opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  // ALU operation requested from the ALU control.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  // ALU operand A select.
  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_RS1    = 2'd1,
    SRC_A_OLD_PC = 2'd2
  } src_a_e;

  // ALU operand B select.
  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_e;

  // Every datapath control produced in one cycle.
  typedef struct packed {
    logic    mem_req;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    pc_write;
    logic    old_pc_write;
    logic    pc_write_cond;
    logic    pc_src;
    src_a_e  alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    logic    mem_2_reg;
    logic    reg_write;
    logic    jump;
    logic    illegal_instr;
  } ctrl_t;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_R)  || (op == OP_I)  || (op == OP_BEQ) ||
           (op == OP_JAL) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mctrl_out_decode.sv
// -----------------------------------------------------------------------------
// mctrl_out_decode
//   Purely combinational control decode: current state + opcode + memory
//   acknowledge -> datapath control bundle. Every control is zero unless the
//   current state asserts it.
// Ports:
//   state_i   in   current controller state
//   opcode_i  in   instruction-register bits [6:0]
//   enable_i  in   fetch permission (only meaningful in FETCH)
//   mem_ack_i in   memory completion for the current request
//   ctrl_o    out  datapath control bundle
// -----------------------------------------------------------------------------
module mctrl_out_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_i,
  input  logic       enable_i,
  input  logic       mem_ack_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    // NOTE: assigning the whole bundle first keeps every path fully
    // specified, so no latch can be inferred for any field.
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        if (enable_i) begin
          ctrl_o.mem_req   = 1'b1;
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.i_or_d    = 1'b0;
          ctrl_o.alu_src_a = SRC_A_PC;
          ctrl_o.alu_src_b = SRC_B_FOUR;
          ctrl_o.alu_op    = ALU_ADD;
          // Mealy: the instruction and PC+4 are captured in the ack cycle.
          ctrl_o.ir_write     = mem_ack_i;
          ctrl_o.pc_write     = mem_ack_i;
          ctrl_o.old_pc_write = mem_ack_i;
        end
      end
      S_DECODE: begin
        // old_pc + imm lands in alu_out as the branch/jump target.
        ctrl_o.alu_src_a     = SRC_A_OLD_PC;
        ctrl_o.alu_src_b     = SRC_B_IMM;
        ctrl_o.alu_op        = ALU_ADD;
        ctrl_o.illegal_instr = ~is_known_op(opcode_i);
      end
      S_EXEC: begin
        unique case (opcode_i)
          OP_R: begin
            ctrl_o.alu_src_a = SRC_A_RS1;
            ctrl_o.alu_src_b = SRC_B_RS2;
            ctrl_o.alu_op    = ALU_RTYPE;
          end
          OP_I, OP_LW, OP_SW: begin
            ctrl_o.alu_src_a = SRC_A_RS1;
            ctrl_o.alu_src_b = SRC_B_IMM;
            ctrl_o.alu_op    = ALU_ADD;
          end
          OP_BEQ: begin
            // The datapath gates pc_write_cond with the ALU zero flag.
            ctrl_o.alu_src_a     = SRC_A_RS1;
            ctrl_o.alu_src_b     = SRC_B_RS2;
            ctrl_o.alu_op        = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_src        = 1'b1;
          end
          OP_JAL: begin
            ctrl_o.pc_write = 1'b1;
            ctrl_o.pc_src   = 1'b1;
            ctrl_o.jump     = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_read  = (opcode_i == OP_LW);
        ctrl_o.mem_write = (opcode_i == OP_SW);
      end
      S_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_2_reg = (opcode_i == OP_LW);
        ctrl_o.jump      = (opcode_i == OP_JAL);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencing controller for a RISC-V core. Steps one shared ALU
//   and one shared memory port through FETCH, DECODE, EXEC, MEM and WB.
//   Holds the state register, next-state logic and the optional retired
//   instruction counter; control decode lives in mctrl_out_decode.
// Configuration:
//   MCTRL_PERF_CNT_EN  when defined, adds the retired_cnt output and counter.
// Parameters:
//   CNT_W          width of the retired-instruction counter
// Ports:
//   clk, arst_n    clock (rising edge), asynchronous active-low reset
//   enable         permits a new fetch (sampled in FETCH only)
//   opcode         instruction-register bits [6:0]
//   zero           ALU zero flag (consumed by the datapath branch gate)
//   mem_ack        memory completion for the current request
//   mem_req, i_or_d, mem_read, mem_write            memory port controls
//   ir_write, pc_write, old_pc_write, pc_write_cond register enables
//   pc_src, alu_src_a, alu_src_b, alu_op            datapath selects
//   mem_2_reg, reg_write, jump                      write-back controls
//   illegal_instr  one-cycle pulse on an unknown opcode in DECODE
//   state          current state, for debug
//   retired_cnt    retired instruction count (MCTRL_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             old_pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_2_reg,
  output logic             reg_write,
  output logic             jump,
  output logic             illegal_instr,
  output logic [2:0]       state
`ifdef MCTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  state_e state_q, state_d;
  logic   retire;
  ctrl_t  ctrl_raw, ctrl;

  // Branch resolution (pc_write_cond & zero) happens in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_FETCH;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and retire
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (enable && mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = is_known_op(opcode) ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        unique case (opcode)
          OP_R, OP_I, OP_JAL: state_d = S_WB;
          OP_LW, OP_SW:       state_d = S_MEM;
          OP_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (opcode == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = (opcode == OP_SW);
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  mctrl_out_decode u_out_decode (
    .state_i   (state_q),
    .opcode_i  (opcode),
    .enable_i  (enable),
    .mem_ack_i (mem_ack),
    .ctrl_o    (ctrl_raw)
  );

  // Reset forces all controls low at once, so a request in flight is dropped
  // immediately and no partial write can be issued while reset is held.
  assign ctrl = arst_n ? ctrl_raw : '0;

  assign mem_req       = ctrl.mem_req;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign old_pc_write  = ctrl.old_pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign mem_2_reg     = ctrl.mem_2_reg;
  assign reg_write     = ctrl.reg_write;
  assign jump          = ctrl.jump;
  assign illegal_instr = ctrl.illegal_instr;
  assign state         = state_q;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter (wraps naturally at 2^CNT_W)
  // ---------------------------------------------------------------------------
`ifdef MCTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`else
  // Without the counter, retire and CNT_W have no consumer.
  logic [CNT_W:0] unused_perf;
  assign unused_perf = {retire, {CNT_W{1'b0}}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. Each stimulus cycle pushes the
//   hand-computed control vector expected in that cycle; a monitor samples
//   the DUT on the falling edge, pops and compares. retired_cnt is checked
//   when MCTRL_PERF_CNT_EN is defined (counter width 2 to reach the wrap).
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int unsigned TB_CNT_W = 2;

  // {state[2:0], req, rd, wr, iod, irw, pcw, opw, pwc, psrc, a[1:0], b[1:0],
  //  op[1:0], m2r, rw, jump, ill}
  typedef logic [21:0] obs_t;

  typedef struct {
    obs_t                o;
    logic [TB_CNT_W-1:0] cnt;
    int                  tag;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n;
  logic enable, zero, mem_ack;
  logic [6:0] opcode;
  logic mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, old_pc_write;
  logic pc_write_cond, pc_src, mem_2_reg, reg_write, jump, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [2:0] state;
`ifdef MCTRL_PERF_CNT_EN
  logic [TB_CNT_W-1:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .enable        (enable),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ack       (mem_ack),
    .mem_req       (mem_req),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .old_pc_write  (old_pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .mem_2_reg     (mem_2_reg),
    .reg_write     (reg_write),
    .jump          (jump),
    .illegal_instr (illegal_instr),
    .state         (state)
`ifdef MCTRL_PERF_CNT_EN
    ,
    .retired_cnt   (retired_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  int tag = 0;
  logic [TB_CNT_W-1:0] exp_cnt = '0;

  task automatic check(input string name, input int t,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, t, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st, input logic [8:0] flags,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] op, input logic [3:0] wb);
    return {st, flags, a, b, op, wb};
  endfunction

  function automatic obs_t sample();
    return {state, mem_req, mem_read, mem_write, i_or_d, ir_write, pc_write,
            old_pc_write, pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op,
            mem_2_reg, reg_write, jump, illegal_instr};
  endfunction

  // Monitor: one comparison per queued cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ctrl", e.tag, 32'(sample()), 32'(e.o));
`ifdef MCTRL_PERF_CNT_EN
        check("retired_cnt", e.tag, 32'(retired_cnt), 32'(e.cnt));
`endif
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic en, input logic ack, input logic [6:0] op,
                      input obs_t o);
    enable  = en;
    mem_ack = ack;
    opcode  = op;
    exp_q.push_back('{o: o, cnt: exp_cnt, tag: tag});
    tag++;
    @(posedge clk);
    #1;
  endtask

  // flags: req rd wr iod | irw pcw opw | pwc psrc
  obs_t F_ACK, F_WAIT, F_IDLE, DEC, DEC_ILL, EX_R, EX_ADDR, EX_BEQ, EX_JAL;
  obs_t MEM_LW, MEM_SW, WB_R, WB_LW, WB_JAL;

  initial begin
    F_ACK   = mk(3'd0, 9'b1100_111_00, 2'd0, 2'd1, 2'b00, 4'b0000);
    F_WAIT  = mk(3'd0, 9'b1100_000_00, 2'd0, 2'd1, 2'b00, 4'b0000);
    F_IDLE  = mk(3'd0, 9'b0000_000_00, 2'd0, 2'd0, 2'b00, 4'b0000);
    DEC     = mk(3'd1, 9'b0000_000_00, 2'd2, 2'd2, 2'b00, 4'b0000);
    DEC_ILL = mk(3'd1, 9'b0000_000_00, 2'd2, 2'd2, 2'b00, 4'b0001);
    EX_R    = mk(3'd2, 9'b0000_000_00, 2'd1, 2'd0, 2'b10, 4'b0000);
    EX_ADDR = mk(3'd2, 9'b0000_000_00, 2'd1, 2'd2, 2'b00, 4'b0000);
    EX_BEQ  = mk(3'd2, 9'b0000_000_11, 2'd1, 2'd0, 2'b01, 4'b0000);
    EX_JAL  = mk(3'd2, 9'b0000_010_01, 2'd0, 2'd0, 2'b00, 4'b0010);
    MEM_LW  = mk(3'd3, 9'b1101_000_00, 2'd0, 2'd0, 2'b00, 4'b0000);
    MEM_SW  = mk(3'd3, 9'b1011_000_00, 2'd0, 2'd0, 2'b00, 4'b0000);
    WB_R    = mk(3'd4, 9'b0000_000_00, 2'd0, 2'd0, 2'b00, 4'b0100);
    WB_LW   = mk(3'd4, 9'b0000_000_00, 2'd0, 2'd0, 2'b00, 4'b1100);
    WB_JAL  = mk(3'd4, 9'b0000_000_00, 2'd0, 2'd0, 2'b00, 4'b0110);

    // Reset with fetch inputs active: everything must stay low.
    arst_n = 1'b0; enable = 1'b1; mem_ack = 1'b1; zero = 1'b0; opcode = 7'b0110011;
    #12;
    check("reset_outputs", -1, 32'(sample()), 32'(F_IDLE));
`ifdef MCTRL_PERF_CNT_EN
    check("reset_cnt", -1, 32'(retired_cnt), 32'd0);
`endif
    enable = 1'b0; mem_ack = 1'b0;
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;

    // R-type, zero-wait memory: FETCH, DECODE, EXEC, WB.
    step(1'b1, 1'b1, 7'b0110011, F_ACK);
    step(1'b1, 1'b1, 7'b0110011, DEC);
    step(1'b1, 1'b1, 7'b0110011, EX_R);
    step(1'b1, 1'b1, 7'b0110011, WB_R);

    // Fetch a LW with no ack, then reset mid-cycle while mem_req is high.
    enable = 1'b1; mem_ack = 1'b0; opcode = 7'b0000011;
    #3;
    check("mid_fetch_req", -2, 32'(mem_req), 32'd1);
`ifdef MCTRL_PERF_CNT_EN
    check("cnt_after_r", -2, 32'(retired_cnt), 32'd1);
`endif
    arst_n = 1'b0;
    #1;
    check("reset_drops_req", -3, 32'(mem_req), 32'd0);
    check("reset_state", -3, 32'(state), 32'd0);
`ifdef MCTRL_PERF_CNT_EN
    check("reset_clears_cnt", -3, 32'(retired_cnt), 32'd0);
`endif
    enable = 1'b0;
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 2'd0;

    // LW with two memory wait cycles: 7 cycles, mem_req held 3 in MEM.
    step(1'b1, 1'b1, 7'b0000011, F_ACK);
    step(1'b1, 1'b1, 7'b0000011, DEC);
    step(1'b1, 1'b1, 7'b0000011, EX_ADDR);
    step(1'b1, 1'b0, 7'b0000011, MEM_LW);
    step(1'b1, 1'b0, 7'b0000011, MEM_LW);
    step(1'b1, 1'b1, 7'b0000011, MEM_LW);
    step(1'b1, 1'b1, 7'b0000011, WB_LW);
    exp_cnt = 2'd1;

    // BEQ taken: retires from EXEC after 3 cycles.
    zero = 1'b1;
    step(1'b1, 1'b1, 7'b1100011, F_ACK);
    step(1'b1, 1'b1, 7'b1100011, DEC);
    step(1'b1, 1'b1, 7'b1100011, EX_BEQ);
    zero = 1'b0;
    exp_cnt = 2'd2;

    // Unknown opcode: illegal pulse in DECODE, not retired.
    step(1'b1, 1'b1, 7'b1111111, F_ACK);
    step(1'b1, 1'b1, 7'b1111111, DEC_ILL);

    // SW with one fetch wait cycle; retires from MEM.
    step(1'b1, 1'b0, 7'b0100011, F_WAIT);
    step(1'b1, 1'b1, 7'b0100011, F_ACK);
    step(1'b1, 1'b1, 7'b0100011, DEC);
    step(1'b1, 1'b1, 7'b0100011, EX_ADDR);
    step(1'b1, 1'b1, 7'b0100011, MEM_SW);
    exp_cnt = 2'd3;

    // enable low for 5 cycles: idle in FETCH, counter holds at all-ones.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 7'b0010011, F_IDLE);

    // I-type retire wraps the counter to 0.
    step(1'b1, 1'b1, 7'b0010011, F_ACK);
    step(1'b1, 1'b1, 7'b0010011, DEC);
    step(1'b1, 1'b1, 7'b0010011, EX_ADDR);
    step(1'b1, 1'b1, 7'b0010011, WB_R);
    exp_cnt = 2'd0;

    // JAL: PC write in EXEC, link write in WB.
    step(1'b1, 1'b1, 7'b1101111, F_ACK);
    step(1'b1, 1'b1, 7'b1101111, DEC);
    step(1'b1, 1'b1, 7'b1101111, EX_JAL);
    step(1'b1, 1'b1, 7'b1101111, WB_JAL);
    exp_cnt = 2'd1;
    step(1'b0, 1'b0, 7'b1101111, F_IDLE);

    // Let the monitor drain the queue (bounded).
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("queue_drained", -4, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
